// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store responder with FIFO write buffer, store-to-load forwarding and a single-port word RAM
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WB_DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReqValid,
  input  logic        ReqWE,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic [3:0]  ByteEn,
  output logic        ReqReady,
  output logic [31:0] ReadData,
  output logic        RespValid,
  output logic        AccessErr
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = $clog2(WB_DEPTH + 1);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] wb_idx  [WB_DEPTH];
  logic [31:0]      wb_data [WB_DEPTH];
  logic [3:0]       wb_be   [WB_DEPTH];
  logic [CNT_W-1:0] wb_cnt;
  logic [CNT_W-1:0] push_pos;

  logic [IDX_W-1:0] req_idx;
  logic             in_range;
  logic             accept;
  logic             load_acc;
  logic             store_acc;
  logic             drain;
  logic             wb_full;

  logic [31:0]      ram_q;
  logic [31:0]      fwd_data;
  logic [3:0]       fwd_be;
  logic [31:0]      fwd_data_q;
  logic [3:0]       fwd_be_q;
  logic             resp_zero_q;
  logic             resp_valid_q;
  logic             err_q;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^Addr[1:0];

  assign req_idx   = Addr[IDX_W+1:2];
  assign in_range  = ({2'b00, Addr[31:2]} < 32'(DEPTH_WORDS));
  assign wb_full   = (wb_cnt == CNT_W'(WB_DEPTH));
  assign ReqReady  = !wb_full;
  assign accept    = ReqValid && ReqReady;
  assign load_acc  = accept && !ReqWE;
  assign store_acc = accept && ReqWE && in_range;
  // The RAM has one port: an accepted load owns it, so drain waits.
  assign drain     = (wb_cnt != '0) && !load_acc;
  assign push_pos  = drain ? (wb_cnt - CNT_W'(1)) : wb_cnt;

  // Entry 0 is the oldest, so ascending order lets the newest store win per lane.
  always_comb begin
    fwd_data = '0;
    fwd_be   = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if ((CNT_W'(i) < wb_cnt) && (wb_idx[i] == req_idx)) begin
        for (int b = 0; b < 4; b++) begin
          if (wb_be[i][b]) begin
            fwd_data[8*b +: 8] = wb_data[i][8*b +: 8];
            fwd_be[b]          = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_acc) begin
      ram_q <= mem[req_idx];
    end
    if (drain) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_be[0][b]) begin
          mem[wb_idx[0]][8*b +: 8] <= wb_data[0][8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (drain) begin
      for (int i = 0; i < WB_DEPTH - 1; i++) begin
        wb_idx[i]  <= wb_idx[i+1];
        wb_data[i] <= wb_data[i+1];
        wb_be[i]   <= wb_be[i+1];
      end
    end
    if (store_acc) begin
      for (int i = 0; i < WB_DEPTH; i++) begin
        if (CNT_W'(i) == push_pos) begin
          wb_idx[i]  <= req_idx;
          wb_data[i] <= WD;
          wb_be[i]   <= ByteEn;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_cnt       <= '0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      resp_zero_q  <= 1'b1;
      fwd_data_q   <= '0;
      fwd_be_q     <= '0;
    end else begin
      if (store_acc && !drain) begin
        wb_cnt <= wb_cnt + CNT_W'(1);
      end else if (!store_acc && drain) begin
        wb_cnt <= wb_cnt - CNT_W'(1);
      end
      resp_valid_q <= load_acc;
      err_q        <= accept && !in_range;
      if (load_acc) begin
        resp_zero_q <= !in_range;
        fwd_data_q  <= fwd_data;
        fwd_be_q    <= fwd_be;
      end
    end
  end

  // Forwarded lanes captured at acceptance overlay the synchronous RAM word.
  always_comb begin
    ReadData = '0;
    if (!resp_zero_q) begin
      for (int b = 0; b < 4; b++) begin
        ReadData[8*b +: 8] = fwd_be_q[b] ? fwd_data_q[8*b +: 8] : ram_q[8*b +: 8];
      end
    end
  end

  assign RespValid = resp_valid_q;
  assign AccessErr = err_q;

endmodule
